// File: rtl/ct_l2c_spsram_ctrl.sv
// Pin-level access controller for one L2C single-port SRAM macro: registered
// request issue, fixed-latency read return and a full-array zero sweep.
module ct_l2c_spsram_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 84,
    parameter int RD_LAT     = 1
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  init_start,
    output logic                  init_busy,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);
    // Reads issued within the last RD_LAT-1 pin cycles block a write.
    localparam int HZ_BITS = (1 << (RD_LAT - 1)) - 1;
    localparam logic [RD_LAT:0] HZ_MASK = HZ_BITS[RD_LAT:0];

    typedef enum logic [1:0] {
        S_INIT_WAIT,
        S_INIT,
        S_IDLE
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [RD_LAT:0]       r_rd_pipe;
    logic                  r_rsp_vld;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_init_done;
    logic [ADDR_WIDTH-1:0] r_sram_a;
    logic                  r_sram_cen;
    logic                  r_sram_gwen;
    logic [DATA_WIDTH-1:0] r_sram_wen;
    logic [DATA_WIDTH-1:0] r_sram_d;

    logic w_hazard;
    logic w_rdy;
    logic w_acc;
    logic w_rd_issue;
    logic w_in_flight;

    assign w_hazard    = |(r_rd_pipe & HZ_MASK);
    assign w_rdy       = (r_state == S_IDLE) & ~init_start & ~(req_vld & req_wr & w_hazard);
    assign w_acc       = req_vld & w_rdy;
    assign w_rd_issue  = w_acc & ~req_wr;
    assign w_in_flight = |r_rd_pipe;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_rd_pipe   <= '0;
            r_rsp_vld   <= 1'b0;
            r_rsp_data  <= '0;
            r_init_done <= 1'b0;
            r_sram_a    <= '0;
            r_sram_cen  <= 1'b1;
            r_sram_gwen <= 1'b1;
            r_sram_wen  <= '1;
            r_sram_d    <= '0;
        end else begin
            r_sram_cen  <= 1'b1;
            r_sram_gwen <= 1'b1;
            r_sram_wen  <= '1;
            r_init_done <= 1'b0;
            // Bit k is set during pin cycle + k of a read; the top bit marks Q valid.
            r_rd_pipe   <= {r_rd_pipe[RD_LAT-1:0], w_rd_issue};
            r_rsp_vld   <= r_rd_pipe[RD_LAT];
            if (r_rd_pipe[RD_LAT]) begin
                r_rsp_data <= sram_q;
            end
            case (r_state)
                S_IDLE: begin
                    if (init_start) begin
                        if (w_in_flight) begin
                            r_state <= S_INIT_WAIT;
                        end else begin
                            r_state <= S_INIT;
                            r_cnt   <= '0;
                        end
                    end else if (w_acc) begin
                        r_sram_cen <= 1'b0;
                        r_sram_a   <= req_addr;
                        if (req_wr) begin
                            r_sram_gwen <= 1'b0;
                            r_sram_wen  <= ~req_wmask;
                            r_sram_d    <= req_wdata;
                        end
                    end
                end
                S_INIT_WAIT: begin
                    if (!w_in_flight) begin
                        r_state <= S_INIT;
                        r_cnt   <= '0;
                    end
                end
                S_INIT: begin
                    r_sram_cen  <= 1'b0;
                    r_sram_gwen <= 1'b0;
                    r_sram_wen  <= '0;
                    r_sram_d    <= '0;
                    r_sram_a    <= r_cnt;
                    r_cnt       <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= S_IDLE;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign req_rdy   = w_rdy;
    assign rsp_vld   = r_rsp_vld;
    assign rsp_data  = r_rsp_data;
    assign init_busy = (r_state != S_IDLE);
    assign init_done = r_init_done;
    assign sram_a    = r_sram_a;
    assign sram_cen  = r_sram_cen;
    assign sram_gwen = r_sram_gwen;
    assign sram_wen  = r_sram_wen;
    assign sram_d    = r_sram_d;

endmodule
